// File: rtl/uart_rx_cfg_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states, majority helper.
// Intended to be shared with the future transmitter as well.
package uart_rx_cfg_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_sampler.sv
// uart_rx_sampler: rx synchroniser, baud counter and bit-sample strobes.
// UART_RX_MAJORITY_EN: the sample is a 2-of-3 vote over three consecutive
// synchronised values; the strobes then fire one clk after the mid-bit point.
module uart_rx_sampler
    import uart_rx_cfg_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic rx,
    input  logic clr_i,     // restart the bit timer (state entry)
    output logic rx_s_o,    // synchronised line
    output logic smp_o,     // bit sample value
    output logic half_o,    // start-bit sample strobe
    output logic tick_o     // data/parity/stop sample strobe
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic          rx_m_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Two-flop synchroniser, idles high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            rx_m_q <= rx;
            rx_s_q <= rx_m_q;
        end
    end

    // Baud counter wraps at CLK_DIV-1 and restarts whenever the FSM changes state.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || cnt_q == CNT_MAX) cnt_d = '0;
    end

    // Baud counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign rx_s_o = rx_s_q;
    assign tick_o = (cnt_q == CNT_MAX);

`ifdef UART_RX_MAJORITY_EN
    logic rx_h1_q, rx_h2_q;

    // History of the synchronised line for the three-point vote.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_h1_q <= 1'b1;
            rx_h2_q <= 1'b1;
        end else begin
            rx_h1_q <= rx_s_q;
            rx_h2_q <= rx_h1_q;
        end
    end

    // Start decision is one clk late, so every later state entry is too;
    // the wrapping tick therefore already lands on mid-bit+1 after START.
    assign half_o = (cnt_q == CW'(CLK_DIV / 2));
    assign smp_o  = maj3(rx_s_q, rx_h1_q, rx_h2_q);
`else
    assign half_o = (cnt_q == CW'(CLK_DIV / 2 - 1));
    assign smp_o  = rx_s_q;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable async serial receiver (5-8 data bits, N/E/O parity,
// 1-2 stop bits) with ready/valid output, error flags and sticky overrun.
// Optional macro UART_RX_MAJORITY_EN enables 3-point majority sampling.
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PARITY_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;     // second stop bit pending
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 deliver;

    logic                 valid_q, perr_o_q, ferr_o_q, ovr_q;
    logic [DATA_BITS-1:0] data_q;

    logic rx_s, smp, half, tick, clr;

    assign clr = (state_d != state_q);

    uart_rx_sampler #(.CLK_DIV(CLK_DIV)) u_sampler (
        .clk    (clk),
        .rstn   (rstn),
        .rx     (rx),
        .clr_i  (clr),
        .rx_s_o (rx_s),
        .smp_o  (smp),
        .half_o (half),
        .tick_o (tick)
    );

    // Frame FSM: next state, shift register, error accumulation, delivery strobe.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        deliver = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (half) begin
                    if (smp) begin
                        state_d = ST_IDLE;          // glitch, not a start bit
                    end else begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d = {smp, shreg_q[DATA_BITS-1:1]};   // LSB first
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    perr_d  = smp != ((^shreg_q) ^ (PARITY == PARITY_ODD));
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    ferr_d = ferr_q | ~smp;
                    if (STOP_BITS == 1 || stop_q) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;           // ready for an immediate start bit
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Output holding register: load on delivery if free or being drained, else drop and flag overrun.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            perr_o_q <= 1'b0;
            ferr_o_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else if (deliver && (!valid_q || rx_ready)) begin
            valid_q  <= 1'b1;
            data_q   <= shreg_q;
            perr_o_q <= perr_q;
            ferr_o_q <= ferr_d;
            if (valid_q) ovr_q <= 1'b0;
        end else if (deliver) begin
            ovr_q <= 1'b1;
        end else if (valid_q && rx_ready) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign rx_valid   = valid_q;
    assign rx_data    = data_q;
    assign parity_err = perr_o_q;
    assign frame_err  = ferr_o_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
